// File: rtl/ex_muldiv_seq_pkg.sv
// Shared types and constants for the sequential RISC-V M-extension unit.
// Opcodes follow the funct3 encoding of the M extension.
package ex_muldiv_seq_pkg;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   localparam int MD_ITERS = 32;
   localparam int MD_CNT_W = $clog2(MD_ITERS);

   // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
   function automatic logic [31:0] md_cneg32(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/ex_muldiv_seq_md_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
// hi/lo form a 64-bit working pair (product, or remainder:quotient).
module md_step
   import ex_muldiv_seq_pkg::*;
(
   input  logic        div_mode,
   input  logic [31:0] opnd,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [31:0] hi_next,
   output logic [31:0] lo_next
);

   logic [32:0] sum;
   logic [32:0] shifted;
   logic [31:0] diff;
   logic        fits;

   always_comb begin
      sum     = {1'b0, hi} + {1'b0, (lo[0] ? opnd : 32'h0)};
      shifted = {hi, lo[31]};
      // Partial remainder is below the divisor, so a successful subtract fits 32 bits.
      diff    = shifted[31:0] - opnd;
      fits    = (shifted >= {1'b0, opnd});
      hi_next = '0;
      lo_next = '0;
      if (div_mode) begin
         if (fits) begin
            hi_next = diff;
            lo_next = {lo[30:0], 1'b1};
         end else begin
            hi_next = shifted[31:0];
            lo_next = {lo[30:0], 1'b0};
         end
      end else begin
         hi_next = sum[32:1];
         lo_next = {sum[0], lo[31:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Sequential multiply/divide unit for the EX stage: 32 radix-2 iterations,
// stalling the pipeline while busy, with early exit for divide special cases.
module ex_muldiv_seq
   import ex_muldiv_seq_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_ex_i,
   input  logic [2:0]  md_op_ex_i,
   input  logic [31:0] src_a_ex_i,
   input  logic [31:0] src_b_ex_i,
   input  logic        flush_ex_i,
   output logic        stall_ex_o,
   output logic        done_ex_o,
   output logic [31:0] md_result_ex_o,
   output logic        busy_o
);

   localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(MD_ITERS - 1);

   md_state_e             state_reg;
   logic [MD_CNT_W-1:0]   cnt_reg;
   logic [31:0]           hi_reg;
   logic [31:0]           lo_reg;
   logic [31:0]           opnd_reg;
   md_op_e                op_reg;
   logic                  neg_q_reg;
   logic                  neg_r_reg;
   logic [31:0]           result_reg;

   md_op_e      op_in;
   logic        a_sgn;
   logic        b_sgn;
   logic        is_div_in;
   logic        div_zero;
   logic        div_ovf;
   logic [31:0] a_mag;
   logic [31:0] b_mag;

   always_comb begin
      op_in     = md_op_e'(md_op_ex_i);
      a_sgn     = 1'b0;
      b_sgn     = 1'b0;
      case (op_in)
         MD_MULH, MD_DIV, MD_REM: begin
            a_sgn = src_a_ex_i[31];
            b_sgn = src_b_ex_i[31];
         end
         MD_MULHSU: a_sgn = src_a_ex_i[31];
         default: ;
      endcase
      is_div_in = md_op_ex_i[2];
      div_zero  = is_div_in && (src_b_ex_i == 32'h0);
      div_ovf   = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                  (src_a_ex_i == 32'h8000_0000) && (src_b_ex_i == 32'hFFFF_FFFF);
      a_mag     = md_cneg32(src_a_ex_i, a_sgn);
      b_mag     = md_cneg32(src_b_ex_i, b_sgn);
   end

   logic        div_mode;
   logic [31:0] step_hi;
   logic [31:0] step_lo;

   assign div_mode = (op_reg == MD_DIV) || (op_reg == MD_DIVU) ||
                     (op_reg == MD_REM) || (op_reg == MD_REMU);

   md_step u_step (
      .div_mode (div_mode),
      .opnd     (opnd_reg),
      .hi       (hi_reg),
      .lo       (lo_reg),
      .hi_next  (step_hi),
      .lo_next  (step_lo)
   );

   // Result as it will stand after the final iteration's step outputs.
   logic [63:0] prod_fix;
   logic [31:0] final_result;

   always_comb begin
      prod_fix = neg_q_reg ? (~{step_hi, step_lo} + 64'd1) : {step_hi, step_lo};
      case (op_reg)
         MD_MUL:                        final_result = prod_fix[31:0];
         MD_MULH, MD_MULHSU, MD_MULHU:  final_result = prod_fix[63:32];
         MD_DIV, MD_DIVU:               final_result = md_cneg32(step_lo, neg_q_reg);
         default:                       final_result = md_cneg32(step_hi, neg_r_reg);
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg  <= MD_IDLE;
         cnt_reg    <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
         opnd_reg   <= '0;
         op_reg     <= MD_MUL;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         result_reg <= '0;
      end else if (flush_ex_i) begin
         state_reg <= MD_IDLE;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            MD_IDLE: begin
               if (start_ex_i) begin
                  op_reg    <= op_in;
                  neg_q_reg <= a_sgn ^ b_sgn;
                  neg_r_reg <= a_sgn;
                  cnt_reg   <= '0;
                  if (div_zero) begin
                     result_reg <= md_op_ex_i[1] ? src_a_ex_i : 32'hFFFF_FFFF;
                     state_reg  <= MD_DONE;
                  end else if (div_ovf) begin
                     result_reg <= md_op_ex_i[1] ? 32'h0 : 32'h8000_0000;
                     state_reg  <= MD_DONE;
                  end else begin
                     hi_reg    <= '0;
                     lo_reg    <= is_div_in ? a_mag : b_mag;
                     opnd_reg  <= is_div_in ? b_mag : a_mag;
                     state_reg <= MD_BUSY;
                  end
               end
            end
            MD_BUSY: begin
               hi_reg  <= step_hi;
               lo_reg  <= step_lo;
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == CNT_LAST) begin
                  result_reg <= final_result;
                  state_reg  <= MD_DONE;
               end
            end
            MD_DONE: state_reg <= MD_IDLE;
            default: state_reg <= MD_IDLE;
         endcase
      end
   end

   assign stall_ex_o     = rst_ni && (((state_reg == MD_IDLE) && start_ex_i) ||
                                      (state_reg == MD_BUSY));
   assign done_ex_o      = (state_reg == MD_DONE);
   assign busy_o         = (state_reg != MD_IDLE);
   assign md_result_ex_o = result_reg;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Scoreboard bench for ex_muldiv_seq: reference results come from native
// SystemVerilog arithmetic and are compared when done_ex_o pulses.
module tb_ex_muldiv_seq;
   import ex_muldiv_seq_pkg::*;

   logic        clk;
   logic        rst_ni;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        stall;
   logic        done;
   logic [31:0] result;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_result = 32'h0;

   typedef struct {
      logic [31:0] res;
      int          lat;
   } exp_t;
   exp_t sb[$];

   ex_muldiv_seq dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .start_ex_i     (start),
      .md_op_ex_i     (op),
      .src_a_ex_i     (a),
      .src_b_ex_i     (b),
      .flush_ex_i     (flush),
      .stall_ex_o     (stall),
      .done_ex_o      (done),
      .md_result_ex_o (result),
      .busy_o         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      longint      sx;
      longint      sy;
      logic [63:0] p;
      logic [31:0] r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r  = 32'h0;
      case (f)
         3'd0: begin p = {32'h0, x} * {32'h0, y}; r = p[31:0]; end
         3'd1: begin p = sx * sy; r = p[63:32]; end
         3'd2: begin p = sx * longint'({32'h0, y}); r = p[63:32]; end
         3'd3: begin p = {32'h0, x} * {32'h0, y}; r = p[63:32]; end
         3'd4: begin
            if (y == 0) r = 32'hFFFF_FFFF;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = $signed(x) / $signed(y);
         end
         3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'd6: begin
            if (y == 0) r = x;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h0;
            else r = $signed(x) % $signed(y);
         end
         default: r = (y == 0) ? x : x % y;
      endcase
      return r;
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      if (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
         return 1;
      return 33;
   endfunction

   task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input bit hold);
      exp_t e;
      exp_t got;
      int   stall_cnt;
      int   lat_seen;
      int   extra;
      e.res = ref_md(f, x, y);
      e.lat = ref_lat(f, x, y);
      sb.push_back(e);
      @(negedge clk);
      op = f; a = x; b = y; start = 1'b1;
      #1;
      stall_cnt = stall ? 1 : 0;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      lat_seen = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done) begin
            lat_seen = k;
            break;
         end
         if (stall) stall_cnt++;
      end
      start = 1'b0;
      got = sb.pop_front();
      check("latency", lat_seen, got.lat);
      check("result", result, got.res);
      check("stall_cycles", stall_cnt, got.lat);
      check("stall_in_done", stall, 1'b0);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
      check("busy_after_done", busy, 1'b0);
      check("result_held", result, got.res);
      if (hold) begin
         extra = 0;
         repeat (40) begin
            @(negedge clk);
            if (done || busy) extra++;
         end
         check("no_restart", extra, 0);
      end
      last_result = got.res;
      $display("op %0d a %08h b %08h result %08h latency %0d", f, x, y, result, lat_seen);
   endtask

   initial begin
      int dones;
      logic [31:0] rb;
      rst_ni = 1'b0; start = 1'b1; flush = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_stall", stall, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_result", result, 32'h0);
      start = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;

      run_op(MD_MUL, 32'd7, 32'hFFFF_FFFD, 1'b0);
      run_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(MD_REM, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(MD_DIVU, 32'd5, 32'd0, 1'b0);
      run_op(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(MD_REMU, 32'h1234_5678, 32'd0, 1'b0);
      run_op(MD_DIV, 32'h8000_0000, 32'd0, 1'b0);

      // Flush at iteration count 10 of a DIVU.
      @(negedge clk);
      op = MD_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush_busy", busy, 1'b0);
      check("flush_stall", stall, 1'b0);
      check("flush_done", done, 1'b0);
      check("flush_result_held", result, last_result);
      $display("flush DIVU at count 10, result held %08h", result);
      run_op(MD_MUL, 32'd12345, 32'd678, 1'b0);

      // Reset in the middle of a busy op.
      @(negedge clk);
      op = MD_MULHU; a = 32'hDEAD_BEEF; b = 32'h1234_5678; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_ni = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_stall", stall, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_result", result, 32'h0);
      @(negedge clk);
      rst_ni = 1'b1;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("midrst_no_done", dones, 0);
      $display("reset mid-busy, done pulses after release %0d", dones);

      run_op(MD_DIVU, 32'hFFFF_FFFF, 32'd3, 1'b1);
      run_op(MD_MUL, 32'd9, 32'd9, 1'b1);

      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 5))
            0:       rb = 32'h0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = 32'd1;
            default: rb = $urandom;
         endcase
         run_op(3'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom, rb, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
